// File: rtl/rf_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_seq_pkg
// Description : Shared definitions for the register-file operation sequencer:
//               default data/address widths, opcode encoding and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_seq_pkg;

  localparam int c_DATA_W = 8;
  localparam int c_ADDR_W = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LDI = 3'b101,
    OP_MOV = 3'b110,
    OP_NOP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

endpackage : rf_seq_pkg
`default_nettype wire

// File: rtl/rf_alu.sv
`default_nettype none
// ============================================================================
// Module      : rf_alu
// Description : Purely combinational ALU for the register-file sequencer.
//               Produces the result, a write-enable (low for NOP) and, when
//               the RF_SEQ_FLAGS_EN macro is defined, a carry/borrow output.
// Ports       : op     - operation code
//               a, b   - register operands
//               imm    - immediate for LDI
//               result - operation result (modulo 2^DATA_W)
//               wr_en  - result should be written back
//               carry  - carry-out (ADD) / borrow (SUB); RF_SEQ_FLAGS_EN only
// Revision    : 1.0 - initial release
// ============================================================================
module rf_alu
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = c_DATA_W
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
`ifdef RF_SEQ_FLAGS_EN
  output logic              carry,
`endif
  output logic              wr_en
);

  always_comb begin
    result = '0;
    wr_en  = 1'b1;
`ifdef RF_SEQ_FLAGS_EN
    carry  = 1'b0;
`endif
    case (op)
`ifdef RF_SEQ_FLAGS_EN
      // One extra bit captures carry-out; for SUB it is set exactly when a < b.
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
`else
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
`endif
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_LDI: result = imm;
      OP_MOV: result = a;
      OP_NOP: wr_en  = 1'b0;
      default: wr_en = 1'b0;
    endcase
  end

endmodule : rf_alu
`default_nettype wire

// File: rtl/rf_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rf_op_sequencer
// Description : Issues one register-to-register operation at a time to a
//               downstream 8x8 register file with registered reads. Each
//               instruction runs IDLE -> READ -> EXEC -> WRITE, so read and
//               write strobes are never active together.
//               Optional feature macro: RF_SEQ_FLAGS_EN (zero/carry flags).
// Ports       : clk, rst_n            - clock, async active-low reset
//               instr_valid/ready     - instruction handshake
//               op, rd, rs1, rs2, imm - instruction fields
//               rf_read, rf_rp1/2     - register file read strobe/addresses
//               rf_out1/2             - registered read data from the file
//               rf_write, rf_wp,
//               rf_wdata              - register file write port
//               done                  - one-cycle pulse after write-back
//               flag_z, flag_c        - flags of last completed operation
// Revision    : 1.0 - initial release
// ============================================================================
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int ADDR_W = c_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  output logic              rf_read,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rp1,
  output logic [ADDR_W-1:0] rf_rp2,
  output logic [ADDR_W-1:0] rf_wp,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c
);

  state_e            r_state;
  op_e               r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_result;
  logic              r_wen;
  logic              r_done;

  logic [DATA_W-1:0] w_result;
  logic              w_wen;
`ifdef RF_SEQ_FLAGS_EN
  logic              w_carry;
  logic              r_flag_z;
  logic              r_flag_c;
`endif

  rf_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (r_op),
    .a      (rf_out1),
    .b      (rf_out2),
    .imm    (r_imm),
    .result (w_result),
`ifdef RF_SEQ_FLAGS_EN
    .carry  (w_carry),
`endif
    .wr_en  (w_wen)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_imm    <= '0;
      r_result <= '0;
      r_wen    <= 1'b0;
      r_done   <= 1'b0;
`ifdef RF_SEQ_FLAGS_EN
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op    <= op_e'(op);
            r_rd    <= rd;
            r_rs1   <= rs1;
            r_rs2   <= rs2;
            r_imm   <= imm;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          // Operands from the file's registered read are valid this cycle.
          r_result <= w_result;
          r_wen    <= w_wen;
`ifdef RF_SEQ_FLAGS_EN
          // NOP (no write-back) leaves the flags of the previous operation.
          if (w_wen) begin
            r_flag_z <= (w_result == '0);
            r_flag_c <= w_carry;
          end
`endif
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode from state; READ and WRITE are distinct states, so the
  // file's read-priority rule never gets a chance to drop a write.
  assign instr_ready = (r_state == S_IDLE);
  assign rf_read     = (r_state == S_READ);
  assign rf_write    = (r_state == S_WRITE) && r_wen;
  assign rf_rp1      = r_rs1;
  assign rf_rp2      = r_rs2;
  assign rf_wp       = r_rd;
  assign rf_wdata    = r_result;
  assign done        = r_done;

`ifdef RF_SEQ_FLAGS_EN
  assign flag_z = r_flag_z;
  assign flag_c = r_flag_c;
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule : rf_op_sequencer
`default_nettype wire

// File: tb/tb_rf_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_op_sequencer
// Description : Directed self-checking bench for rf_op_sequencer with a
//               behavioural 8x8 register file (registered read, read has
//               priority over write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_op_sequencer;

`ifdef RF_SEQ_FLAGS_EN
  localparam bit c_FL = 1'b1;
`else
  localparam bit c_FL = 1'b0;
`endif

  localparam logic [2:0] c_ADD = 3'b000;
  localparam logic [2:0] c_SUB = 3'b001;
  localparam logic [2:0] c_XOR = 3'b100;
  localparam logic [2:0] c_LDI = 3'b101;
  localparam logic [2:0] c_MOV = 3'b110;
  localparam logic [2:0] c_NOP = 3'b111;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] op;
  logic [2:0] rd;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic [7:0] imm;
  logic       rf_read;
  logic       rf_write;
  logic [2:0] rf_rp1;
  logic [2:0] rf_rp2;
  logic [2:0] rf_wp;
  logic [7:0] rf_wdata;
  logic [7:0] rf_out1;
  logic [7:0] rf_out2;
  logic       done;
  logic       flag_z;
  logic       flag_c;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] mem [8] = '{default: 8'h00};

  rf_op_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op          (op),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm         (imm),
    .rf_read     (rf_read),
    .rf_write    (rf_write),
    .rf_rp1      (rf_rp1),
    .rf_rp2      (rf_rp2),
    .rf_wp       (rf_wp),
    .rf_wdata    (rf_wdata),
    .rf_out1     (rf_out1),
    .rf_out2     (rf_out2),
    .done        (done),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: registered read, read wins over write.
  always @(posedge clk) begin
    if (rf_read) begin
      rf_out1 <= mem[rf_rp1];
      rf_out2 <= mem[rf_rp2];
    end else if (rf_write) begin
      mem[rf_wp] <= rf_wdata;
    end
  end

  // Issues one instruction starting from a falling edge; returns the number
  // of cycles after the accept edge until done is seen, and whether rf_write
  // was ever observed. Ends on the falling edge where done is high.
  task automatic run_instr(input logic [2:0] o, input logic [2:0] d,
                           input logic [2:0] s1, input logic [2:0] s2,
                           input logic [7:0] im, output int lat,
                           output bit wr_seen);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    instr_valid = 1'b1;
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wr_seen = 1'b0;
    lat = 1;
    @(negedge clk);
    if (rf_write) wr_seen = 1'b1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (rf_write) wr_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [39:0] got;
    tests_run++;
    got = {instr_ready, rf_read, rf_write, done, flag_z, flag_c,
           rf_rp1, rf_rp2, rf_wp, rf_wdata, 10'd0};
    if (got !== {6'b100000, 3'd0, 3'd0, 3'd0, 8'd0, 10'd0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h required %h", got,
               {6'b100000, 3'd0, 3'd0, 3'd0, 8'd0, 10'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b done=%b required ready=1 done=0",
               instr_ready, done);
    end
  endtask

  task automatic test_add();
    int lat; bit wr;
    run_instr(c_LDI, 3'd1, 3'd0, 3'd0, 8'h7F, lat, wr);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++; $display("FAIL ldi_latency: got %0d required 4", lat);
    end
    run_instr(c_LDI, 3'd2, 3'd0, 3'd0, 8'h01, lat, wr);
    tests_run++;
    if (instr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL ready_with_done: got %b required 1", instr_ready);
    end
    run_instr(c_ADD, 3'd3, 3'd1, 3'd2, 8'h00, lat, wr);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++; $display("FAIL add_latency: got %0d required 4", lat);
    end
    tests_run++;
    if (mem[3] !== 8'h80) begin
      tests_failed++; $display("FAIL add_r3: got %h required 80", mem[3]);
    end
    tests_run++;
    if ({flag_z, flag_c} !== 2'b00) begin
      tests_failed++; $display("FAIL add_flags: got zc=%b%b required 00", flag_z, flag_c);
    end
  endtask

  task automatic test_add_wrap();
    int lat; bit wr;
    run_instr(c_LDI, 3'd1, 3'd0, 3'd0, 8'hFF, lat, wr);
    run_instr(c_LDI, 3'd2, 3'd0, 3'd0, 8'h01, lat, wr);
    run_instr(c_ADD, 3'd4, 3'd1, 3'd2, 8'h00, lat, wr);
    tests_run++;
    if (mem[4] !== 8'h00) begin
      tests_failed++; $display("FAIL wrap_r4: got %h required 00", mem[4]);
    end
    tests_run++;
    if ({flag_z, flag_c} !== {c_FL, c_FL}) begin
      tests_failed++;
      $display("FAIL wrap_flags: got zc=%b%b required %b%b", flag_z, flag_c, c_FL, c_FL);
    end
  endtask

  task automatic test_sub_xor();
    int lat; bit wr;
    run_instr(c_LDI, 3'd1, 3'd0, 3'd0, 8'h03, lat, wr);
    run_instr(c_SUB, 3'd5, 3'd2, 3'd1, 8'h00, lat, wr);
    tests_run++;
    if (mem[5] !== 8'hFE) begin
      tests_failed++; $display("FAIL sub_r5: got %h required fe", mem[5]);
    end
    tests_run++;
    if ({flag_z, flag_c} !== {1'b0, c_FL}) begin
      tests_failed++;
      $display("FAIL sub_flags: got zc=%b%b required 0%b", flag_z, flag_c, c_FL);
    end
    run_instr(c_XOR, 3'd6, 3'd5, 3'd5, 8'h00, lat, wr);
    tests_run++;
    if (mem[6] !== 8'h00) begin
      tests_failed++; $display("FAIL xor_r6: got %h required 00", mem[6]);
    end
    tests_run++;
    if ({flag_z, flag_c} !== {c_FL, 1'b0}) begin
      tests_failed++;
      $display("FAIL xor_flags: got zc=%b%b required %b0", flag_z, flag_c, c_FL);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    instr_valid = 1'b1;
    op = c_LDI; rd = 3'd3; rs1 = 3'd0; rs2 = 3'd0; imm = 8'h5A;
    @(posedge clk);
    #1;
    op = c_MOV; rd = 3'd7; rs1 = 3'd3; rs2 = 3'd0; imm = 8'h00;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      got = {instr_ready, done, rf_read, rf_write};
      exp = {(cyc == 4 || cyc == 8), (cyc == 4 || cyc == 8),
             (cyc == 1 || cyc == 5), (cyc == 3 || cyc == 7)};
      tests_run++;
      if (got !== exp || (rf_read && rf_write)) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d: got rdy/done/rd/wr=%b required %b", cyc, got, exp);
      end
    end
    instr_valid = 1'b0;
    tests_run++;
    if (mem[7] !== 8'h5A) begin
      tests_failed++; $display("FAIL b2b_raw_r7: got %h required 5a", mem[7]);
    end
  endtask

  task automatic test_nop();
    int lat; bit wr;
    // r1=03, r2=01: SUB r5=r2-r1 gives z=0 c=1 as the flag baseline.
    run_instr(c_SUB, 3'd5, 3'd2, 3'd1, 8'h00, lat, wr);
    run_instr(c_NOP, 3'd1, 3'd2, 3'd2, 8'h77, lat, wr);
    tests_run++;
    if (wr !== 1'b0) begin
      tests_failed++; $display("FAIL nop_write: got rf_write seen=%b required 0", wr);
    end
    tests_run++;
    if (lat !== 4) begin
      tests_failed++; $display("FAIL nop_done: got latency %0d required 4", lat);
    end
    tests_run++;
    if (mem[1] !== 8'h03) begin
      tests_failed++; $display("FAIL nop_r1: got %h required 03", mem[1]);
    end
    tests_run++;
    if ({flag_z, flag_c} !== {1'b0, c_FL}) begin
      tests_failed++;
      $display("FAIL nop_flags: got zc=%b%b required 0%b", flag_z, flag_c, c_FL);
    end
  endtask

  task automatic test_reset_in_write();
    int lat; bit wr;
    logic [21:0] got;
    instr_valid = 1'b1;
    op = c_LDI; rd = 3'd2; rs1 = 3'd0; rs2 = 3'd0; imm = 8'hAA;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (rf_write !== 1'b1) begin
      tests_failed++; $display("FAIL rst_pre_write: got rf_write=%b required 1", rf_write);
    end
    rst_n = 1'b0;
    #1;
    got = {instr_ready, rf_read, rf_write, done, flag_z, flag_c, rf_wp, rf_rp1, rf_wdata};
    tests_run++;
    if (got !== {6'b100000, 3'd0, 3'd0, 8'd0}) begin
      tests_failed++;
      $display("FAIL rst_in_write_outputs: got %h required %h", got,
               {6'b100000, 3'd0, 3'd0, 8'd0});
    end
    @(negedge clk);
    tests_run++;
    if (mem[2] !== 8'h01) begin
      tests_failed++; $display("FAIL rst_in_write_r2: got %h required 01", mem[2]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_instr(c_LDI, 3'd4, 3'd0, 3'd0, 8'h33, lat, wr);
    tests_run++;
    if (mem[4] !== 8'h33 || lat !== 4) begin
      tests_failed++;
      $display("FAIL rst_recover: got r4=%h lat=%0d required r4=33 lat=4", mem[4], lat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    op = 3'd0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0; imm = 8'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_add();
    test_add_wrap();
    test_sub_xor();
    test_back_to_back();
    test_nop();
    test_reset_in_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_rf_op_sequencer
`default_nettype wire
